// File: rtl/conv_mac_pipe.sv
// rtl/conv_mac_pipe.sv - pipelined signed/unsigned multiply-accumulate with first/last burst tagging
module conv_mac_pipe #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 8,
    parameter int din1_WIDTH = 21,
    parameter int dout_WIDTH = 32,
    parameter int SIGNED     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic                  in_first,
    input  logic                  in_last,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  out_valid
);

    localparam int PW = din0_WIDTH + din1_WIDTH;

    generate
        if (dout_WIDTH < PW || NUM_STAGE < 1) begin : g_bad_cfg
            $fatal(1, "conv_mac_pipe: dout_WIDTH must be >= din0_WIDTH+din1_WIDTH and NUM_STAGE >= 1");
        end
    endgenerate

    logic unused_id;
    assign unused_id = ^ID;

    // Multiplying operands already extended to dout_WIDTH yields the extended product modulo 2^dout_WIDTH.
    logic                  ext0, ext1;
    logic [dout_WIDTH-1:0] a_x, b_x, p_ext;

    assign ext0  = (SIGNED != 0) & din0[din0_WIDTH-1];
    assign ext1  = (SIGNED != 0) & din1[din1_WIDTH-1];
    assign a_x   = {{(dout_WIDTH-din0_WIDTH){ext0}}, din0};
    assign b_x   = {{(dout_WIDTH-din1_WIDTH){ext1}}, din1};
    assign p_ext = a_x * b_x;

    logic [dout_WIDTH-1:0] f_p;
    logic                  f_v, f_f, f_l;

    generate
        if (NUM_STAGE == 1) begin : g_comb
            assign f_p = p_ext;
            assign f_v = in_valid;
            assign f_f = in_valid & in_first;
            assign f_l = in_valid & in_last;
        end else begin : g_pipe
            logic [dout_WIDTH-1:0] pr [NUM_STAGE-1];
            logic                  vr [NUM_STAGE-1];
            logic                  fr [NUM_STAGE-1];
            logic                  lr [NUM_STAGE-1];

            // Bubbles enter with first/last cleared so they can never disturb the accumulator.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < NUM_STAGE-1; i++) begin
                        pr[i] <= '0;
                        vr[i] <= 1'b0;
                        fr[i] <= 1'b0;
                        lr[i] <= 1'b0;
                    end
                end else if (ce) begin
                    pr[0] <= p_ext;
                    vr[0] <= in_valid;
                    fr[0] <= in_valid & in_first;
                    lr[0] <= in_valid & in_last;
                    for (int i = 1; i < NUM_STAGE-1; i++) begin
                        pr[i] <= pr[i-1];
                        vr[i] <= vr[i-1];
                        fr[i] <= fr[i-1];
                        lr[i] <= lr[i-1];
                    end
                end
            end

            assign f_p = pr[NUM_STAGE-2];
            assign f_v = vr[NUM_STAGE-2];
            assign f_f = fr[NUM_STAGE-2];
            assign f_l = lr[NUM_STAGE-2];
        end
    endgenerate

    logic [dout_WIDTH-1:0] acc, acc_next;

    assign acc_next = f_f ? f_p : acc + f_p;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            dout      <= '0;
            out_valid <= 1'b0;
        end else if (ce) begin
            out_valid <= 1'b0;
            if (f_v) begin
                acc <= acc_next;
                if (f_l) begin
                    dout      <= acc_next;
                    out_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_mac_pipe.sv
// tb/tb_conv_mac_pipe.sv - five parameterisations of conv_mac_pipe against an arithmetic burst model
module tb_conv_mac_pipe;

    logic        clk = 1'b0;
    logic        reset, ce, in_valid, in_first, in_last;
    logic [7:0]  din0;
    logic [20:0] din1;
    logic [31:0] dout0, dout1, dout2;
    logic [15:0] dout3;
    logic [28:0] dout4;
    logic        ov0, ov1, ov2, ov3, ov4;

    always #5 clk = ~clk;

    conv_mac_pipe u0 (.clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .din0(din0), .din1(din1), .dout(dout0), .out_valid(ov0));
    conv_mac_pipe #(.NUM_STAGE(1)) u1 (.clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
        .in_first(in_first), .in_last(in_last), .din0(din0), .din1(din1), .dout(dout1), .out_valid(ov1));
    conv_mac_pipe #(.NUM_STAGE(5)) u2 (.clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
        .in_first(in_first), .in_last(in_last), .din0(din0), .din1(din1), .dout(dout2), .out_valid(ov2));
    conv_mac_pipe #(.din1_WIDTH(8), .dout_WIDTH(16), .SIGNED(1)) u3 (.clk(clk), .reset(reset), .ce(ce),
        .in_valid(in_valid), .in_first(in_first), .in_last(in_last), .din0(din0), .din1(din1[7:0]),
        .dout(dout3), .out_valid(ov3));
    conv_mac_pipe #(.dout_WIDTH(29)) u4 (.clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
        .in_first(in_first), .in_last(in_last), .din0(din0), .din1(din1), .dout(dout4), .out_valid(ov4));

    typedef struct {int inst; longint due; logic [63:0] val;} ev_t;
    typedef struct {int inst; logic [63:0] val;} pulse_t;

    ev_t         pend[$];
    pulse_t      plog[$];
    logic [63:0] macc [5];
    logic [63:0] mdout [5];
    logic        mov [5];
    longint      kce;
    int          n_chk = 0;
    int          n_err = 0;

    function automatic int wid(input int i);
        case (i)
            3:       return 16;
            4:       return 29;
            default: return 32;
        endcase
    endfunction

    function automatic int lat(input int i);
        case (i)
            1:       return 1;
            2:       return 5;
            default: return 3;
        endcase
    endfunction

    function automatic logic [63:0] msk(input int i);
        return (64'd1 << wid(i)) - 64'd1;
    endfunction

    function automatic logic [63:0] prod(input int i, input logic [7:0] a, input logic [20:0] b);
        longint x, y;
        if (i == 3) begin
            x = longint'($signed(a));
            y = longint'($signed(b[7:0]));
        end else begin
            x = longint'({56'd0, a});
            y = longint'({43'd0, b});
        end
        return 64'(x * y) & msk(i);
    endfunction

    function automatic logic [63:0] get_dout(input int i);
        case (i)
            0:       return 64'(dout0);
            1:       return 64'(dout1);
            2:       return 64'(dout2);
            3:       return 64'(dout3);
            default: return 64'(dout4);
        endcase
    endfunction

    function automatic logic get_ov(input int i);
        case (i)
            0:       return ov0;
            1:       return ov1;
            2:       return ov2;
            3:       return ov3;
            default: return ov4;
        endcase
    endfunction

    task automatic model_reset();
        pend.delete();
        kce = 0;
        for (int i = 0; i < 5; i++) begin
            macc[i]  = '0;
            mdout[i] = '0;
            mov[i]   = 1'b0;
        end
    endtask

    // Sums are formed at acceptance; the result is due NUM_STAGE ce-edges later, counting the accepting edge.
    task automatic model_edge(input logic v, input logic f, input logic l,
                              input logic [7:0] a, input logic [20:0] b);
        kce++;
        for (int i = 0; i < 5; i++) begin
            if (v) begin
                macc[i] = f ? prod(i, a, b) : (macc[i] + prod(i, a, b)) & msk(i);
                if (l) pend.push_back('{i, kce + longint'(lat(i)) - 1, macc[i]});
            end
        end
        for (int i = 0; i < 5; i++) begin
            mov[i] = 1'b0;
            for (int j = 0; j < pend.size(); j++) begin
                if (pend[j].inst == i && pend[j].due == kce) begin
                    mov[i]   = 1'b1;
                    mdout[i] = pend[j].val;
                    pend.delete(j);
                    break;
                end
            end
        end
    endtask

    task automatic check_all(input logic rec);
        for (int i = 0; i < 5; i++) begin
            n_chk++;
            assert (get_ov(i) === mov[i]) else begin
                n_err++;
                $error("FAIL out_valid inst%0d observed=%0b expected=%0b", i, get_ov(i), mov[i]);
            end
            n_chk++;
            assert (get_dout(i) === mdout[i]) else begin
                n_err++;
                $error("FAIL dout inst%0d observed=%0h expected=%0h", i, get_dout(i), mdout[i]);
            end
            if (rec && get_ov(i) === 1'b1) plog.push_back('{i, get_dout(i)});
        end
    endtask

    task automatic cyc(input logic v, input logic f, input logic l,
                       input logic [7:0] a, input logic [20:0] b, input logic c);
        in_valid = v;
        in_first = f;
        in_last  = l;
        din0     = a;
        din1     = b;
        ce       = c;
        @(posedge clk);
        if (c) model_edge(v, f, l, a, b);
        @(negedge clk);
        check_all(c);
    endtask

    task automatic drain(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 8'd0, 21'd0, 1'b1);
    endtask

    task automatic rst_pulse();
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        model_reset();
        check_all(1'b0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_all(1'b0);
    endtask

    task automatic chk_pulses(input int i, input string tag, input int n,
                              input logic [63:0] e0, input logic [63:0] e1);
        int          cnt = 0;
        logic [63:0] v0  = '0;
        logic [63:0] v1  = '0;
        foreach (plog[j]) begin
            if (plog[j].inst == i) begin
                if (cnt == 0) v0 = plog[j].val;
                else if (cnt == 1) v1 = plog[j].val;
                cnt++;
            end
        end
        n_chk++;
        assert (cnt == n && v0 === e0 && (n < 2 || v1 === e1)) else begin
            n_err++;
            $error("FAIL %s inst%0d observed=%0d pulses %0d,%0d expected=%0d pulses %0d,%0d",
                   tag, i, cnt, v0, v1, n, e0, e1);
        end
    endtask

    initial begin
        reset    = 1'b1;
        ce       = 1'b1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        din0     = '0;
        din1     = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all(1'b0);
        reset = 1'b0;

        cyc(1, 1, 1, 8'd255, 21'h1FFFFF, 1);
        drain(6);
        chk_pulses(0, "single_max", 1, 64'd534773505, 64'd0);
        chk_pulses(3, "single_signed_m1", 1, 64'd1, 64'd0);
        plog.delete();

        for (int k = 1; k <= 4; k++) cyc(1, k == 1, k == 4, 8'(k), 21'd10, 1);
        drain(6);
        chk_pulses(0, "burst4", 1, 64'd100, 64'd0);
        chk_pulses(2, "burst4_s5", 1, 64'd100, 64'd0);
        plog.delete();

        cyc(1, 1, 0, 8'd1, 21'd10, 1);
        cyc(1, 0, 0, 8'd2, 21'd10, 1);
        cyc(0, 0, 0, 8'd0, 21'd0, 0);
        cyc(0, 0, 0, 8'd0, 21'd0, 0);
        cyc(0, 0, 0, 8'd0, 21'd0, 1);
        cyc(1, 0, 0, 8'd3, 21'd10, 1);
        cyc(1, 0, 1, 8'd4, 21'd10, 1);
        drain(2);
        cyc(0, 0, 0, 8'd0, 21'd0, 0);
        cyc(0, 0, 0, 8'd0, 21'd0, 0);
        drain(6);
        chk_pulses(0, "burst4_stall", 1, 64'd100, 64'd0);
        plog.delete();

        cyc(1, 1, 0, 8'h80, 21'd127, 1);
        cyc(1, 0, 1, 8'hFF, 21'h0000FF, 1);
        drain(6);
        chk_pulses(3, "signed_burst", 1, 64'hC081, 64'd0);
        plog.delete();
        cyc(1, 1, 1, 8'd127, 21'd127, 1);
        drain(6);
        chk_pulses(3, "signed_single", 1, 64'h3F01, 64'd0);
        plog.delete();

        cyc(1, 1, 0, 8'd7, 21'd9, 1);
        cyc(1, 0, 1, 8'd8, 21'd9, 1);
        rst_pulse();
        cyc(1, 1, 0, 8'd2, 21'd3, 1);
        cyc(1, 0, 1, 8'd4, 21'd5, 1);
        drain(6);
        chk_pulses(0, "after_reset", 1, 64'd26, 64'd0);
        chk_pulses(2, "after_reset_s5", 1, 64'd26, 64'd0);
        plog.delete();

        rst_pulse();
        cyc(1, 0, 1, 8'd3, 21'd3, 1);
        cyc(1, 1, 0, 8'd5, 21'd5, 1);
        cyc(1, 0, 1, 8'd1, 21'd1, 1);
        drain(8);
        chk_pulses(1, "b2b_s1", 2, 64'd9, 64'd26);
        chk_pulses(2, "b2b_s5", 2, 64'd9, 64'd26);
        plog.delete();

        cyc(1, 1, 0, 8'd255, 21'h1FFFFF, 1);
        cyc(1, 0, 1, 8'd255, 21'h1FFFFF, 1);
        drain(6);
        chk_pulses(4, "wrap29", 1, 64'd532676098, 64'd0);
        chk_pulses(0, "nowrap32", 1, 64'd1069547010, 64'd0);
        plog.delete();

        for (int k = 0; k < 400; k++) begin
            if (k % 97 == 50) rst_pulse();
            cyc(($urandom % 4) != 0, ($urandom % 5) == 0, ($urandom % 4) == 0,
                8'($urandom), 21'($urandom), ($urandom % 5) != 0);
        end
        drain(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
